// File: rtl/ov_pwr_seq_v1.sv
// Power-up/reset sequencer for the OV sensor: walks PWDN -> RST -> SETTLE -> READY
// with fixed per-phase edge counts, then pulses start_o to launch SCCB configuration.
module ov_pwr_seq_v1 #(
  parameter logic [19:0] T_PWDN   = 20'd1000,
  parameter logic [19:0] T_RST    = 20'd1000,
  parameter logic [19:0] T_SETTLE = 20'd20000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       reinit_i,
  output logic       pwdn_o,
  output logic       rst_n_o,
  output logic       ready_o,
  output logic       start_o,
  output logic [1:0] phase_o
);

  typedef enum logic [1:0] {
    ST_PWDN   = 2'b00,
    ST_RST    = 2'b01,
    ST_SETTLE = 2'b10,
    ST_READY  = 2'b11
  } state_t;

  // Terminal count per phase; a zero parameter behaves as a one-edge phase.
  localparam logic [19:0] LAST_PWDN   = (T_PWDN   == 20'd0) ? 20'd0 : T_PWDN   - 20'd1;
  localparam logic [19:0] LAST_RST    = (T_RST    == 20'd0) ? 20'd0 : T_RST    - 20'd1;
  localparam logic [19:0] LAST_SETTLE = (T_SETTLE == 20'd0) ? 20'd0 : T_SETTLE - 20'd1;

  state_t      state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic        pwdn_reg, pwdn_next;
  logic        rst_n_reg, rst_n_next;
  logic        ready_reg, ready_next;
  logic        start_reg, start_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_PWDN;
      cnt_reg   <= 20'd0;
      pwdn_reg  <= 1'b1;
      rst_n_reg <= 1'b0;
      ready_reg <= 1'b0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pwdn_reg  <= pwdn_next;
      rst_n_reg <= rst_n_next;
      ready_reg <= ready_next;
      start_reg <= start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = 20'd0;
    case (state_reg)
      ST_PWDN: begin
        if (cnt_reg == LAST_PWDN) state_next = ST_RST;
        else                      cnt_next   = cnt_reg + 20'd1;
      end
      ST_RST: begin
        if (cnt_reg == LAST_RST) state_next = ST_SETTLE;
        else                     cnt_next   = cnt_reg + 20'd1;
      end
      ST_SETTLE: begin
        if (cnt_reg == LAST_SETTLE) state_next = ST_READY;
        else                        cnt_next   = cnt_reg + 20'd1;
      end
      ST_READY: begin
        if (reinit_i) state_next = ST_PWDN;
      end
      default: state_next = ST_PWDN;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    pwdn_next  = (state_next == ST_PWDN);
    rst_n_next = (state_next == ST_SETTLE) || (state_next == ST_READY);
    ready_next = (state_next == ST_READY);
    start_next = (state_next == ST_READY) && (state_reg != ST_READY);
  end

  assign pwdn_o  = pwdn_reg;
  assign rst_n_o = rst_n_reg;
  assign ready_o = ready_reg;
  assign start_o = start_reg;
  assign phase_o = state_reg;

endmodule

// File: tb/tb_ov_pwr_seq_v1.sv
// Directed bench for ov_pwr_seq_v1: short-phase instance (4/3/5) plus a zero-parameter instance.
module tb_ov_pwr_seq_v1;

  logic       clk = 1'b0;
  logic       rst = 1'b1, reinit = 1'b0;
  logic       pwdn, rst_n, ready, start;
  logic [1:0] phase;
  logic       rst_z = 1'b1, reinit_z = 1'b0;
  logic       pwdn_z, rst_n_z, ready_z, start_z;
  logic [1:0] phase_z;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ov_pwr_seq_v1 #(.T_PWDN(20'd4), .T_RST(20'd3), .T_SETTLE(20'd5)) u_dut (
    .clk_i(clk), .rst_i(rst), .reinit_i(reinit),
    .pwdn_o(pwdn), .rst_n_o(rst_n), .ready_o(ready), .start_o(start), .phase_o(phase)
  );

  ov_pwr_seq_v1 #(.T_PWDN(20'd0), .T_RST(20'd0), .T_SETTLE(20'd0)) u_zero (
    .clk_i(clk), .rst_i(rst_z), .reinit_i(reinit_z),
    .pwdn_o(pwdn_z), .rst_n_o(rst_n_z), .ready_o(ready_z), .start_o(start_z), .phase_o(phase_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {phase, pwdn, rst_n, ready, start} e edges after release of a 4/3/5 sequence.
  function automatic logic [5:0] seq_exp(int e);
    logic [1:0] ph;
    ph = (e < 4) ? 2'd0 : (e < 7) ? 2'd1 : (e < 12) ? 2'd2 : 2'd3;
    return {ph, ph == 2'd0, ph[1], ph == 2'd3, e == 12};
  endfunction

  task automatic test_reset();
    logic [5:0] obs, obs_z;
    rst = 1'b1; rst_z = 1'b1;
    tick(); tick();
    obs   = {phase, pwdn, rst_n, ready, start};
    obs_z = {phase_z, pwdn_z, rst_n_z, ready_z, start_z};
    checks++;
    if (obs !== 6'b001000) begin
      errors++; $display("FAIL reset got %b want %b", obs, 6'b001000);
    end
    checks++;
    if (obs_z !== 6'b001000) begin
      errors++; $display("FAIL reset_zero got %b want %b", obs_z, 6'b001000);
    end
    $display("reset: obs=%b obs_zero=%b", obs, obs_z);
  endtask

  task automatic test_nominal();
    logic [5:0] obs;
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      obs = {phase, pwdn, rst_n, ready, start};
      checks++;
      if (obs !== seq_exp(e)) begin
        errors++; $display("FAIL nominal e=%0d got %b want %b", e, obs, seq_exp(e));
      end
      $display("nominal e=%0d obs=%b", e, obs);
    end
  endtask

  task automatic test_reinit();
    logic [5:0] obs;
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    obs = {phase, pwdn, rst_n, ready, start};
    checks++;
    if (obs !== 6'b001000) begin
      errors++; $display("FAIL reinit_edge got %b want %b", obs, 6'b001000);
    end
    $display("reinit e=0 obs=%b", obs);
    for (int e = 1; e <= 13; e++) begin
      tick();
      obs = {phase, pwdn, rst_n, ready, start};
      checks++;
      if (obs !== seq_exp(e)) begin
        errors++; $display("FAIL reinit e=%0d got %b want %b", e, obs, seq_exp(e));
      end
      $display("reinit e=%0d obs=%b", e, obs);
    end
  endtask

  task automatic test_ignored();
    logic [5:0] obs;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      reinit = (e >= 5 && e <= 11);
      tick();
      obs = {phase, pwdn, rst_n, ready, start};
      checks++;
      if (obs !== seq_exp(e)) begin
        errors++; $display("FAIL ignored e=%0d got %b want %b", e, obs, seq_exp(e));
      end
      $display("ignored e=%0d reinit=%b obs=%b", e, reinit, obs);
    end
    reinit = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [5:0] obs;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      obs = {phase, pwdn, rst_n, ready, start};
      checks++;
      if (obs !== seq_exp(e)) begin
        errors++; $display("FAIL mid_pre e=%0d got %b want %b", e, obs, seq_exp(e));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {phase, pwdn, rst_n, ready, start};
    checks++;
    if (obs !== 6'b001000) begin
      errors++; $display("FAIL mid_reset got %b want %b", obs, 6'b001000);
    end
    $display("mid_reset obs=%b", obs);
    for (int e = 1; e <= 13; e++) begin
      tick();
      obs = {phase, pwdn, rst_n, ready, start};
      checks++;
      if (obs !== seq_exp(e)) begin
        errors++; $display("FAIL mid_post e=%0d got %b want %b", e, obs, seq_exp(e));
      end
      $display("mid_post e=%0d obs=%b", e, obs);
    end
  endtask

  task automatic test_zero();
    logic [5:0] obs;
    logic [5:0] zexp [1:4];
    zexp[1] = 6'b010000;
    zexp[2] = 6'b100100;
    zexp[3] = 6'b110111;
    zexp[4] = 6'b110110;
    rst_z = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      obs = {phase_z, pwdn_z, rst_n_z, ready_z, start_z};
      checks++;
      if (obs !== zexp[e]) begin
        errors++; $display("FAIL zero e=%0d got %b want %b", e, obs, zexp[e]);
      end
      $display("zero e=%0d obs=%b", e, obs);
    end
  endtask

  task automatic test_continuous();
    logic [5:0] obs;
    rst = 1'b1; reinit = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      obs = {phase, pwdn, rst_n, ready, start};
      checks++;
      if (obs !== seq_exp(e % 13)) begin
        errors++; $display("FAIL continuous e=%0d got %b want %b", e, obs, seq_exp(e % 13));
      end
      $display("continuous e=%0d obs=%b", e, obs);
    end
    reinit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reinit();
    test_ignored();
    test_mid_reset();
    test_zero();
    test_continuous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
